dual_rr_priority_encoder: RTL and testbench

- Parametrised successor to the 12-bit dual priority encoder: finds the two highest-priority active requests among N and reports their indices.
- Adds registered outputs, valid flags, and a selectable round-robin mode whose priority pointer rotates on an ack handshake.
- Sits in front of shared-resource arbiters and display multiplexers that need a primary and a backup grant each cycle.

---
 rtl/dual_rr_priority_encoder_pkg.sv | 17 +
 rtl/dual_rr_priority_encoder_search.sv | 52 +++++
 rtl/dual_rr_priority_encoder.sv | 68 ++++++
 tb/tb_dual_rr_priority_encoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dual_rr_priority_encoder_pkg.sv
// Shared constants, width helper and mode encoding for the dual round-robin
// priority encoder.
package dual_prio_pkg;

    localparam int DEFAULT_N = 12;

    // Index width that stays at least one bit wide for tiny N.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/dual_rr_priority_encoder_search.sv
// Combinational search for the first two active requests, walking downward
// from a start index and wrapping from 0 back to N-1.
module dual_priority_search
    import dual_prio_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_first,
    output logic         o_first_valid,
    output logic [W-1:0] o_second,
    output logic         o_second_valid
);

    // Index arithmetic wraps at N, not at 2^W.
    function automatic logic [W-1:0] wrap_sub(input logic [W-1:0] s, input int k);
        int t;
        t = int'(s) - k;
        if (t < 0) t = t + N;
        return W'(t);
    endfunction

    logic [N-1:0] w_rot;

    // Position k of w_rot is the k-th channel in search order.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_rot[k] = i_req[wrap_sub(i_start, k)];
        end
    end

    always_comb begin
        o_first        = '0;
        o_first_valid  = 1'b0;
        o_second       = '0;
        o_second_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (w_rot[k]) begin
                if (!o_first_valid) begin
                    o_first_valid = 1'b1;
                    o_first       = wrap_sub(i_start, k);
                end else if (!o_second_valid) begin
                    o_second_valid = 1'b1;
                    o_second       = wrap_sub(i_start, k);
                end
            end
        end
    end

endmodule

// File: rtl/dual_rr_priority_encoder.sv
// Registered primary/backup grant encoder with fixed or round-robin priority;
// the pointer rotates so the acknowledged channel drops to lowest priority.
module dual_rr_priority_encoder
    import dual_prio_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic [W-1:0] first,
    output logic         first_valid,
    output logic [W-1:0] second,
    output logic         second_valid
);

    logic [W-1:0] r_ptr;
    logic [W-1:0] w_next_ptr;
    logic [W-1:0] w_start;
    logic         w_rr;
    logic [W-1:0] w_first;
    logic         w_first_valid;
    logic [W-1:0] w_second;
    logic         w_second_valid;

    assign w_rr = (mode_e'(mode) == MODE_RR);

    // Ack only counts against a real grant in round-robin mode.
    always_comb begin
        w_next_ptr = r_ptr;
        if (w_rr && ack && first_valid) begin
            w_next_ptr = (first == '0) ? W'(N - 1) : first - 1'b1;
        end
    end

    assign w_start = w_rr ? w_next_ptr : W'(N - 1);

    dual_priority_search #(
        .N(N)
    ) u_search (
        .i_req         (req),
        .i_start       (w_start),
        .o_first       (w_first),
        .o_first_valid (w_first_valid),
        .o_second      (w_second),
        .o_second_valid(w_second_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= W'(N - 1);
            first        <= '0;
            first_valid  <= 1'b0;
            second       <= '0;
            second_valid <= 1'b0;
        end else begin
            r_ptr        <= w_next_ptr;
            first        <= w_first;
            first_valid  <= w_first_valid;
            second       <= w_second;
            second_valid <= w_second_valid;
        end
    end

endmodule

// File: tb/tb_dual_rr_priority_encoder.sv
// Scoreboard bench for dual_rr_priority_encoder at N=12 and N=5.
module tb_dual_rr_priority_encoder;

    typedef struct packed {
        logic [3:0] first;
        logic       fv;
        logic [3:0] second;
        logic       sv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        ack = 1'b0;
    logic [11:0] req12 = '0;
    logic [4:0]  req5 = '0;
    logic [3:0]  f12, s12;
    logic        fv12, sv12;
    logic [2:0]  f5, s5;
    logic        fv5, sv5;

    exp_t q12[$];
    exp_t q5[$];
    exp_t e12, e5;
    exp_t cur12, cur5;
    int   ptr12, ptr5;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dual_rr_priority_encoder #(.N(12)) u_dut12 (
        .clk(clk), .reset(reset), .req(req12), .mode(mode), .ack(ack),
        .first(f12), .first_valid(fv12), .second(s12), .second_valid(sv12)
    );

    dual_rr_priority_encoder #(.N(5)) u_dut5 (
        .clk(clk), .reset(reset), .req(req5), .mode(mode), .ack(ack),
        .first(f5), .first_valid(fv5), .second(s5), .second_valid(sv5)
    );

    // Reference: rank each active channel by its distance below start s;
    // the smallest two ranks win.
    function automatic exp_t search(input int n, input logic [11:0] rq, input int s);
        exp_t e;
        int b1, b2, r1, r2, rank;
        e = '0; b1 = -1; b2 = -1; r1 = n; r2 = n;
        for (int i = 0; i < n; i++) begin
            if (rq[i]) begin
                rank = (s - i + n) % n;
                if (rank < r1) begin
                    r2 = r1; b2 = b1; r1 = rank; b1 = i;
                end else if (rank < r2) begin
                    r2 = rank; b2 = i;
                end
            end
        end
        if (b1 >= 0) begin e.fv = 1'b1; e.first = 4'(b1); end
        if (b2 >= 0) begin e.sv = 1'b1; e.second = 4'(b2); end
        return e;
    endfunction

    task automatic model_step(input int n, input logic [11:0] rq, input logic md,
                              input logic ak, input logic rs,
                              inout int ptr, inout exp_t cur);
        int nptr;
        if (rs) begin
            cur = '0;
            ptr = n - 1;
        end else begin
            nptr = ptr;
            if (md && ak && cur.fv) nptr = (cur.first == 0) ? n - 1 : int'(cur.first) - 1;
            cur = search(n, rq, md ? nptr : n - 1);
            ptr = nptr;
        end
    endtask

    task automatic drive(input logic [11:0] r12, input logic [4:0] r5,
                         input logic md, input logic ak, input logic rs);
        @(negedge clk);
        req12 = r12; req5 = r5; mode = md; ack = ak; reset = rs;
        model_step(12, r12, md, ak, rs, ptr12, cur12);
        q12.push_back(cur12);
        model_step(5, {7'b0, r5}, md, ak, rs, ptr5, cur5);
        q5.push_back(cur5);
    endtask

    // Monitor: the DUT presents a result every cycle; compare one per edge.
    always @(posedge clk) begin
        #1;
        if (q12.size() > 0) begin
            e12 = q12.pop_front();
            checks++;
            if ({f12, fv12, s12, sv12} !== {e12.first, e12.fv, e12.second, e12.sv}) begin
                errors++;
                $display("FAIL n12_out t=%0t: got first=%0d fv=%0b second=%0d sv=%0b, expected first=%0d fv=%0b second=%0d sv=%0b",
                         $time, f12, fv12, s12, sv12, e12.first, e12.fv, e12.second, e12.sv);
            end
        end
        if (q5.size() > 0) begin
            e5 = q5.pop_front();
            checks++;
            if ({1'b0, f5, fv5, 1'b0, s5, sv5} !== {e5.first, e5.fv, e5.second, e5.sv}) begin
                errors++;
                $display("FAIL n5_out t=%0t: got first=%0d fv=%0b second=%0d sv=%0b, expected first=%0d fv=%0b second=%0d sv=%0b",
                         $time, f5, fv5, s5, sv5, e5.first, e5.fv, e5.second, e5.sv);
            end
            checks++;
            if (f5 >= 3'd5 || s5 >= 3'd5) begin
                errors++;
                $display("FAIL n5_range t=%0t: got first=%0d second=%0d, expected both below 5",
                         $time, f5, s5);
            end
        end
    end

    initial begin
        ptr12 = 11; ptr5 = 4; cur12 = '0; cur5 = '0;
        drive('0, '0, 0, 0, 1);
        drive('0, '0, 0, 0, 1);
        // Fixed priority patterns, single request, then idle.
        drive(12'b101010101010, 5'b10101, 0, 0, 0);
        drive(12'b000000011010, 5'b00110, 0, 0, 0);
        drive(12'b000000010000, 5'b00001, 0, 0, 0);
        drive(12'b000000000000, 5'b00000, 0, 0, 0);
        // Round-robin with ack held high from reset release.
        drive('0, '0, 1, 1, 1);
        for (int i = 0; i < 8; i++) drive(12'hAAA, 5'b11111, 1, 1, 0);
        // Single acks on a sparse pattern.
        drive('0, '0, 1, 0, 1);
        drive(12'b010000011010, 5'b10010, 1, 0, 0);
        drive(12'b010000011010, 5'b10010, 1, 1, 0);
        drive(12'b010000011010, 5'b10010, 1, 0, 0);
        drive(12'b010000011010, 5'b10010, 1, 1, 0);
        drive(12'b010000011010, 5'b10010, 1, 1, 0);
        drive(12'b010000011010, 5'b10010, 1, 0, 0);
        // Ack with no valid grant, then ack in fixed mode, then back to RR.
        drive(12'h000, 5'b00000, 1, 1, 0);
        drive(12'h000, 5'b00000, 1, 1, 0);
        drive(12'hAAA, 5'b11011, 0, 1, 0);
        drive(12'hAAA, 5'b11011, 0, 1, 0);
        drive(12'hAAA, 5'b11011, 1, 0, 0);
        // Reset in the middle of a rotation.
        for (int i = 0; i < 3; i++) drive(12'hAAA, 5'b11111, 1, 1, 0);
        drive(12'hAAA, 5'b11111, 1, 1, 1);
        drive(12'hAAA, 5'b11111, 1, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [11:0] r12;
            logic [4:0]  r5;
            r12 = ($urandom_range(0, 3) == 0) ? 12'(1 << $urandom_range(0, 11)) : 12'($urandom);
            r5  = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
            drive(r12, r5, 1'($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 59) == 0));
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q12.size() != 0 || q5.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q12.size(), q5.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
